// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {instr, pc} with flush.
// Latency 1 cycle push-to-head (no bypass); in_ready drops only when full, a full queue ignores same-cycle push.
module fetch_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  logic            push;
  logic            pop;

  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = occ;
  assign out_instr = out_valid ? mem[rd_ptr].instr : NOP;
  assign out_pc    = out_valid ? mem[rd_ptr].pc    : 32'h0;

  // Array contents survive flush/reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue (DEPTH=2): reset, ordering, full, streaming, flush, async reset.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.DEPTH(2), .NOP(NOP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = 32'hA000_0000 | pc;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, NOP);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    step();
    step();
    reset = 1'b1;

    // First push visible one cycle later
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    check("t1_pre_instr", out_instr, NOP);
    step();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_instr", out_instr, 32'h00500093);
    check("t1_pc", out_pc, 32'h0);
    check("t1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_drain", 32'(count), 32'd0);

    // Fill with out_ready low; third entry held by fetch
    drive(1'b1, 32'h0); step();
    drive(1'b1, 32'h4); step();
    check("t2_full_count", 32'(count), 32'd2);
    check("t2_full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h8); step();
    check("t2_hold_count", 32'(count), 32'd2);
    check("t2_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    check("t2_pop1_pc", out_pc, 32'h4);
    check("t2_pop1_count", 32'(count), 32'd1);
    check("t2_pop1_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 32'h0);
    check("t2_pc8", out_pc, 32'h8);
    check("t2_pc8_instr", out_instr, 32'hA000_0008);
    check("t2_pc8_count", 32'(count), 32'd1);
    step();
    check("t2_empty", 32'(count), 32'd0);

    // Streaming with pointer wrap
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i * 4));
      step();
      check("t3_pc", out_pc, 32'(i * 4));
      check("t3_count", 32'(count), 32'd1);
    end
    drive(1'b0, 32'h0);
    step();
    check("t3_end_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Flush discards buffered entries and the in-flight push
    drive(1'b1, 32'h10); step();
    drive(1'b1, 32'h14); step();
    check("t4_full", 32'(count), 32'd2);
    drive(1'b1, 32'h18);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    check("t4_count", 32'(count), 32'd0);
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_instr_nop", out_instr, NOP);
    drive(1'b1, 32'h40); step();
    drive(1'b0, 32'h0);
    check("t4_pc40", out_pc, 32'h40);
    check("t4_pc40_count", 32'(count), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Full queue with simultaneous pop and in_valid: pop only
    drive(1'b1, 32'h20); step();
    drive(1'b1, 32'h24); step();
    drive(1'b1, 32'h28); out_ready = 1'b1;
    step();
    drive(1'b0, 32'h0); out_ready = 1'b0;
    check("t5_count", 32'(count), 32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_pc", out_pc, 32'h24);

    // Stalled head stays stable
    step();
    check("t5_stable_pc", out_pc, 32'h24);

    // Async reset mid-cycle with two entries
    drive(1'b1, 32'h30); step();
    drive(1'b0, 32'h0);
    check("t6_pre_count", 32'(count), 32'd2);
    #3 reset = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_pc", out_pc, 32'h0);
    step();
    reset = 1'b1;
    check("t6_post_count", 32'(count), 32'd0);
    drive(1'b1, 32'h50); step();
    drive(1'b0, 32'h0);
    check("t6_resume_pc", out_pc, 32'h50);
    check("t6_resume_count", 32'(count), 32'd1);

    // Empty with out_ready high: no underflow
    out_ready = 1'b1;
    step();
    step();
    check("t7_empty_count", 32'(count), 32'd0);
    check("t7_empty_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
